// File: rtl/motor3_pkg.sv
// motor3_pkg: shared phase codes, FSM state encoding and the six-step
// commutation table for the three-phase commutator.
// Optional feature macro: MOTOR3_BRAKE_EN adds the BRAKE state.
package motor3_pkg;

  // Half-bridge drive codes; code 3 is never produced.
  localparam logic [1:0] FLOAT = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] UP    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
`ifdef MOTOR3_BRAKE_EN
    DRIVE = 2'd2,
    BRAKE = 2'd3
`else
    DRIVE = 2'd2
`endif
  } state_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
  } phaseSet_t;

  localparam phaseSet_t ALL_FLOAT = '{a: FLOAT, b: FLOAT, c: FLOAT};
  localparam phaseSet_t ALL_DOWN  = '{a: DOWN,  b: DOWN,  c: DOWN};

  // Six-step table; indices 6 and 7 are unreachable and float everything.
  function automatic phaseSet_t stepCodes(input logic [2:0] idx);
    phaseSet_t codes;
    case (idx)
      3'd0:    codes = '{a: UP,    b: DOWN,  c: FLOAT};
      3'd1:    codes = '{a: UP,    b: FLOAT, c: DOWN};
      3'd2:    codes = '{a: FLOAT, b: UP,    c: DOWN};
      3'd3:    codes = '{a: DOWN,  b: UP,    c: FLOAT};
      3'd4:    codes = '{a: DOWN,  b: FLOAT, c: UP};
      3'd5:    codes = '{a: FLOAT, b: DOWN,  c: UP};
      default: codes = ALL_FLOAT;
    endcase
    return codes;
  endfunction

  // Neighbouring step index with wrap at both ends of 0..5.
  function automatic logic [2:0] nextStep(input logic [2:0] idx, input logic dir);
    logic [2:0] nxt;
    if (!dir) begin
      nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      nxt = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/motor3_deadtime_cnt.sv
// motor3_deadtime_cnt: 8-bit down-counter timing the dead interval.
// Loading sets the start value; it then decrements and parks at zero.
module motor3_deadtime_cnt (
  input  logic       clki,
  input  logic       rsti,
  input  logic       load,
  input  logic [7:0] value,
  output logic       done
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load takes priority; otherwise count down and stop at zero without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register with synchronous reset to zero.
  always_ff @(posedge clki) begin
    if (rsti) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 8'd0);

endmodule

// File: rtl/motor3_commutator.sv
// motor3_commutator: six-step BLDC commutation sequencer with dead-time
// insertion, one-deep step request buffering and a sticky overrun flag.
// Optional feature macro: MOTOR3_BRAKE_EN adds brakei and a low-side BRAKE state.
module motor3_commutator
  import motor3_pkg::*;
#(
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic       clki,
  input  logic       rsti,
  input  logic       enablei,
  input  logic       diri,
  input  logic       stepi,
`ifdef MOTOR3_BRAKE_EN
  input  logic       brakei,
`endif
  output logic [1:0] phAO,
  output logic [1:0] phBO,
  output logic [1:0] phCO,
  output logic [2:0] stepIdxO,
  output logic       busyO,
  output logic       overrunO
);

  // The counter starts one below the interval so that DEAD lasts DEAD_CYC cycles.
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);

  state_t     state_q,   state_d;
  phaseSet_t  phase_q,   phase_d;
  logic [2:0] stepIdx_q, stepIdx_d;
  logic [2:0] target_q,  target_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
`ifdef MOTOR3_BRAKE_EN
  logic       brakeTarget_q, brakeTarget_d;
`endif

  logic      cntLoad;
  logic      cntDone;
  phaseSet_t nxtCodes;

  motor3_deadtime_cnt u_deadCnt (
    .clki  (clki),
    .rsti  (rsti),
    .load  (cntLoad),
    .value (DEAD_LOAD),
    .done  (cntDone)
  );

  // Codes of the neighbouring step in the currently requested direction.
  assign nxtCodes = stepCodes(nextStep(stepIdx_q, diri));

  // State and datapath registers; reset wins over everything, even mid-DEAD.
  always_ff @(posedge clki) begin
    if (rsti) begin
      state_q   <= IDLE;
      phase_q   <= ALL_FLOAT;
      stepIdx_q <= 3'd0;
      target_q  <= 3'd0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MOTOR3_BRAKE_EN
      brakeTarget_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stepIdx_q <= stepIdx_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
`ifdef MOTOR3_BRAKE_EN
      brakeTarget_q <= brakeTarget_d;
`endif
    end
  end

  // Next-state logic; every entry to DEAD reloads the dead-time counter.
  always_comb begin
    state_d = state_q;
    cntLoad = 1'b0;
    if (!enablei) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD;
          cntLoad = 1'b1;
        end
        DEAD: begin
`ifdef MOTOR3_BRAKE_EN
          if (cntDone) state_d = brakeTarget_q ? BRAKE : DRIVE;
`else
          if (cntDone) state_d = DRIVE;
`endif
        end
        DRIVE: begin
`ifdef MOTOR3_BRAKE_EN
          if (brakei || stepi || pending_q) begin
`else
          if (stepi || pending_q) begin
`endif
            state_d = DEAD;
            cntLoad = 1'b1;
          end
        end
`ifdef MOTOR3_BRAKE_EN
        BRAKE: begin
          if (!brakei) begin
            state_d = DEAD;
            cntLoad = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Phase codes, step index, request buffer and overrun flag for the next cycle.
  always_comb begin
    phase_d   = phase_q;
    stepIdx_d = stepIdx_q;
    target_d  = target_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
`ifdef MOTOR3_BRAKE_EN
    brakeTarget_d = brakeTarget_q;
`endif
    if (!enablei) begin
      phase_d   = ALL_FLOAT;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_d   = ALL_FLOAT;
          target_d  = stepIdx_q;
          pending_d = 1'b0;
`ifdef MOTOR3_BRAKE_EN
          brakeTarget_d = 1'b0;
`endif
        end
        DEAD: begin
`ifdef MOTOR3_BRAKE_EN
          if (stepi && !brakeTarget_q) begin
`else
          if (stepi) begin
`endif
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
          if (cntDone) begin
`ifdef MOTOR3_BRAKE_EN
            if (brakeTarget_q) begin
              phase_d   = ALL_DOWN;
              pending_d = 1'b0;
            end else begin
              stepIdx_d = target_q;
              phase_d   = stepCodes(target_q);
            end
`else
            stepIdx_d = target_q;
            phase_d   = stepCodes(target_q);
`endif
          end
        end
        DRIVE: begin
`ifdef MOTOR3_BRAKE_EN
          if (brakei) begin
            phase_d       = ALL_FLOAT;
            brakeTarget_d = 1'b1;
            pending_d     = 1'b0;
          end else
`endif
          if (stepi || pending_q) begin
            target_d  = nextStep(stepIdx_q, diri);
            phase_d.a = (phase_q.a == nxtCodes.a) ? phase_q.a : FLOAT;
            phase_d.b = (phase_q.b == nxtCodes.b) ? phase_q.b : FLOAT;
            phase_d.c = (phase_q.c == nxtCodes.c) ? phase_q.c : FLOAT;
            pending_d = pending_q && stepi;
          end
        end
`ifdef MOTOR3_BRAKE_EN
        BRAKE: begin
          if (!brakei) begin
            phase_d       = ALL_FLOAT;
            target_d      = stepIdx_q;
            brakeTarget_d = 1'b0;
          end
        end
`endif
        default: phase_d = ALL_FLOAT;
      endcase
    end
  end

  assign phAO     = phase_q.a;
  assign phBO     = phase_q.b;
  assign phCO     = phase_q.c;
  assign stepIdxO = stepIdx_q;
  assign busyO    = (state_q == DEAD);
  assign overrunO = overrun_q;

endmodule

// File: tb/tb_motor3_commutator.sv
// tb_motor3_commutator: directed and random checks of motor3_commutator
// against a cycle-level behavioural model of the commutation rules.
// Optional feature macro: MOTOR3_BRAKE_EN enables the brake sequence checks.
module tb_motor3_commutator;

  localparam int DEAD = 4;

  logic clk = 1'b0;
  logic rst, en, dir, step;
`ifdef MOTOR3_BRAKE_EN
  logic brake;
`endif
  logic [1:0] phA, phB, phC;
  logic [2:0] idx;
  logic       busy, ovr;

  int total = 0;
  int bad   = 0;

  int tbl [6][3] = '{'{2,1,0}, '{2,0,1}, '{0,2,1}, '{1,2,0}, '{1,0,2}, '{0,1,2}};

  // Reference model state: running flag, dead cycles left, step, target, pending, overrun, phases.
  bit mRun;
  int mDead;
  int mStep;
  int mTgt;
  bit mPend;
  bit mOvr;
  int mPh [3];
  int prevPh [3];

  always #5 clk = ~clk;

  motor3_commutator #(.DEAD_CYC(DEAD)) dut (
    .clki     (clk),
    .rsti     (rst),
    .enablei  (en),
    .diri     (dir),
    .stepi    (step),
`ifdef MOTOR3_BRAKE_EN
    .brakei   (brake),
`endif
    .phAO     (phA),
    .phBO     (phB),
    .phCO     (phC),
    .stepIdxO (idx),
    .busyO    (busy),
    .overrunO (ovr)
  );

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, given the inputs sampled at that edge.
  task automatic modelEdge(input bit r, input bit e, input bit s, input bit d);
    if (r) begin
      mRun = 0; mDead = 0; mStep = 0; mTgt = 0; mPend = 0; mOvr = 0;
      for (int k = 0; k < 3; k++) mPh[k] = 0;
    end else if (!e) begin
      mRun = 0; mDead = 0; mPend = 0;
      for (int k = 0; k < 3; k++) mPh[k] = 0;
    end else if (!mRun) begin
      mRun = 1; mDead = DEAD; mTgt = mStep; mPend = 0;
      for (int k = 0; k < 3; k++) mPh[k] = 0;
    end else if (mDead > 0) begin
      if (s) begin
        if (mPend) mOvr = 1;
        else       mPend = 1;
      end
      mDead--;
      if (mDead == 0) begin
        mStep = mTgt;
        for (int k = 0; k < 3; k++) mPh[k] = tbl[mStep][k];
      end
    end else if (s || mPend) begin
      mTgt = (mStep + (d ? 5 : 1)) % 6;
      for (int k = 0; k < 3; k++) begin
        if (tbl[mStep][k] != tbl[mTgt][k]) mPh[k] = 0;
      end
      mPend = mPend && s;
      mDead = DEAD;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] obsPh [3];
    int illegal;
    obsPh[0] = phA;
    obsPh[1] = phB;
    obsPh[2] = phC;
    checkValue({tag, ".phA"},  8'(phA),  8'(mPh[0]));
    checkValue({tag, ".phB"},  8'(phB),  8'(mPh[1]));
    checkValue({tag, ".phC"},  8'(phC),  8'(mPh[2]));
    checkValue({tag, ".step"}, 8'(idx),  8'(mStep));
    checkValue({tag, ".busy"}, 8'(busy), 8'(mDead > 0));
    checkValue({tag, ".ovr"},  8'(ovr),  8'(mOvr));
    illegal = 0;
    for (int k = 0; k < 3; k++) begin
      if (obsPh[k] == 2'd3 ||
          (prevPh[k] == 1 && obsPh[k] == 2'd2) ||
          (prevPh[k] == 2 && obsPh[k] == 2'd1)) illegal++;
      prevPh[k] = int'(obsPh[k]);
    end
    checkValue({tag, ".legal"}, 8'(illegal), 8'd0);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit s, input bit d, input string tag);
    rst  = r;
    en   = e;
    step = s;
    dir  = d;
    @(posedge clk);
    modelEdge(r, e, s, d);
    #1;
    checkOutput(tag);
    step = 1'b0;
  endtask

`ifdef MOTOR3_BRAKE_EN
  task automatic checkBrakeCycle(input string tag, input int a, input int b, input int c, input int bz);
    @(posedge clk);
    #1;
    checkValue({tag, ".phA"},  8'(phA),  8'(a));
    checkValue({tag, ".phB"},  8'(phB),  8'(b));
    checkValue({tag, ".phC"},  8'(phC),  8'(c));
    checkValue({tag, ".busy"}, 8'(busy), 8'(bz));
    checkValue({tag, ".step"}, 8'(idx),  8'(mStep));
    checkValue({tag, ".ovr"},  8'(ovr),  8'(mOvr));
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; step = 1'b0; dir = 1'b0;
`ifdef MOTOR3_BRAKE_EN
    brake = 1'b0;
`endif
    for (int k = 0; k < 3; k++) prevPh[k] = 0;
    modelEdge(1, 0, 0, 0);

    // Reset, and reset overriding enable and step.
    applyStimulus(1, 0, 0, 0, "reset");
    applyStimulus(1, 1, 1, 0, "resetPrio");

    // Enable from IDLE: dead interval, then step 0 codes.
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, "enable");

    // Forward step 0 -> 1.
    applyStimulus(0, 1, 1, 0, "fwd");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, "fwd");

    // Reverse 1 -> 0, then 0 -> 5 across the wrap.
    applyStimulus(0, 1, 1, 1, "rev");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, "rev");
    applyStimulus(0, 1, 1, 1, "revWrap");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, "revWrap");

    // Three back-to-back strobes: one in flight, one pending, one dropped.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, "triple");
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, "triple");

    // Disable mid-dead with a coincident strobe, then re-enable.
    applyStimulus(0, 1, 1, 0, "disable");
    applyStimulus(0, 1, 1, 0, "disable");
    applyStimulus(0, 0, 1, 0, "disable");
    applyStimulus(0, 0, 1, 0, "idleStep");
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, "reenable");

    // Reset in the middle of a dead interval.
    applyStimulus(0, 1, 1, 0, "midReset");
    applyStimulus(0, 1, 0, 0, "midReset");
    applyStimulus(1, 1, 0, 0, "midReset");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, "afterReset");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(bit'($urandom_range(0, 149) == 0),
                    bit'($urandom_range(0, 19) != 0),
                    bit'($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 1)),
                    "random");
    end

`ifdef MOTOR3_BRAKE_EN
    // Settle into DRIVE, then brake and release.
    for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 0, "settle");
    brake = 1'b1;
    for (int i = 0; i < DEAD; i++) checkBrakeCycle("brakeDead", 0, 0, 0, 1);
    checkBrakeCycle("brakeOn", 1, 1, 1, 0);
    step = 1'b1;
    checkBrakeCycle("brakeStep", 1, 1, 1, 0);
    step = 1'b0;
    checkBrakeCycle("brakeHold", 1, 1, 1, 0);
    brake = 1'b0;
    for (int i = 0; i < DEAD; i++) checkBrakeCycle("releaseDead", 0, 0, 0, 1);
    checkBrakeCycle("release", tbl[mStep][0], tbl[mStep][1], tbl[mStep][2], 0);
    for (int k = 0; k < 3; k++) prevPh[k] = tbl[mStep][k];
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, "afterBrake");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor3_commutator.md
MOTOR3_COMMUTATOR -- requirements
Module: motor3_commutator

Interface
REQ-001 SHALL have parameter DEAD_CYC, default 16 (range 1..255): dead-time length in clki cycles.
REQ-002 SHALL have port clki  input  1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rsti  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port enablei  input  1: 1 = commutation running; 0 = all phases floated.
REQ-005 SHALL have port diri  input  1: 0 = forward (step +1); 1 = reverse (step -1).
REQ-006 SHALL have port stepi  input  1: single-cycle strobe requesting advance to the next commutation step.
REQ-007 SHALL have ports phAO, phBO, phCO  output  2 each: half-bridge drive codes, per phase (0 = float, 1 = low side on, 2 = high side on).
REQ-008 SHALL have port stepIdxO  output  3: current commutation step, 0..5.
REQ-009 SHALL have port busyO  output  1: 1 while a dead-time interval is in progress.
REQ-010 SHALL have port overrunO  output  1: sticky flag, set when a stepi is dropped.

Function
REQ-011 SHALL implement the states IDLE, DEAD and DRIVE, plus BRAKE when MOTOR3_BRAKE_EN is defined.
REQ-012 SHALL use this step table, as (A,B,C): 0=(2,1,0), 1=(2,0,1), 2=(0,2,1), 3=(1,2,0), 4=(1,0,2), 5=(0,1,2).
REQ-013 SHALL never output code 3 on any phase.
REQ-014 SHALL never drive any phase directly from 1 to 2 or from 2 to 1; every such change passes through 0 for at least DEAD_CYC cycles.
REQ-015 In IDLE, all phases SHALL be 0 and busyO 0.
REQ-016 On IDLE with enablei=1: SHALL go to DEAD with all phases 0, then after DEAD_CYC cycles go to DRIVE with the codes for the current stepIdxO.
REQ-017 On stepi=1 in DRIVE: SHALL compute next = stepIdxO+1 mod 6 (diri=0) or stepIdxO-1 mod 6 (diri=1), with wrap 5->0 and 0->5.
REQ-018 In that transition, phases whose code differs between the current and next step SHALL go to 0 on the following cycle, and unchanged phases SHALL hold.
REQ-019 Next step, stepIdxO update: SHALL enter DEAD for DEAD_CYC cycles, then apply the next-step codes and update stepIdxO in the same cycle as DRIVE entry.
REQ-020 Total latency from stepi to the new codes SHALL be DEAD_CYC+1 cycles.
REQ-021 busyO SHALL be 1 exactly during the DEAD cycles.
REQ-022 A stepi during DEAD SHALL be held as one pending request (direction sampled at apply time); it SHALL be serviced immediately on DRIVE entry, which starts a new DEAD on the next cycle.
REQ-023 A stepi arriving while a request is already pending SHALL be dropped and SHALL set overrunO.
REQ-024 stepi in IDLE SHALL be ignored and SHALL NOT set overrunO.
REQ-025 enablei=0 in any state SHALL force all phases to 0 on the next cycle, go to IDLE, clear the pending request and hold stepIdxO.
REQ-026 If stepi and enablei fall in the same cycle, enablei SHALL win: the step is discarded and overrunO is not set.
REQ-027 overrunO SHALL be cleared only by reset.
REQ-028 The dead-time counter SHALL be 8 bits, loaded with DEAD_CYC-1, with a terminal count at 0; no wrap is permitted.

Reset
REQ-029 rsti=1 SHALL give state IDLE, phA/B/CO=0, stepIdxO=0, busyO=0, overrunO=0, pending cleared and counter 0, all on the next clki edge.
REQ-030 rsti SHALL take precedence over all other inputs, including in the middle of DEAD.

Configuration
REQ-031 Macro MOTOR3_BRAKE_EN defined SHALL add input brakei (1 bit).
REQ-032 With MOTOR3_BRAKE_EN, brakei=1 while enabled SHALL float all phases, run DEAD, then enter BRAKE with all phases=1 (low-side braking).
REQ-033 In BRAKE, stepi SHALL be ignored; brakei=0 SHALL float all phases, run DEAD, then return to DRIVE at the held stepIdxO.
REQ-034 With MOTOR3_BRAKE_EN, enablei=0 SHALL still override brakei.
REQ-035 Without MOTOR3_BRAKE_EN, there SHALL be no brakei port and no BRAKE state, and behaviour SHALL be identical to REQ-011..028.

Structure
REQ-036 Package motor3_pkg SHALL hold the phase-code constants (FLOAT=0, DOWN=1, UP=2), the state encoding and the 6-entry step-table function.
REQ-037 Sub-module motor3_deadtime_cnt SHALL hold the load/decrement/terminal-count logic (inputs load, value; output done).
REQ-038 Each phase output SHALL feed one existing half-bridge driver instance at top level; this block does not instantiate those drivers.

Verification
REQ-039 Reset, then enablei=1 with DEAD_CYC=4: phases 0 for 4 cycles, then (2,1,0); busyO high for exactly 4 cycles.
REQ-040 From step 0, stepi with diri=0: phases B and C go 0 next cycle while A holds 2; after 4 cycles (2,0,1) and stepIdxO=1.
REQ-041 From step 0, stepi with diri=1: stepIdxO=5 and final codes (0,1,2); no phase ever shows 1<->2 without an intervening 0.
REQ-042 Three stepi strobes within one DEAD: the first is in progress, the second pending, the third dropped with overrunO=1; the pending step completes and stepIdxO advances by 2 in total.
REQ-043 enablei=0 in mid-DEAD: all phases 0 next cycle, IDLE, pending cleared; rsti in mid-DEAD gives all outputs 0 and stepIdxO=0.
REQ-044 With MOTOR3_BRAKE_EN: brakei=1 in DRIVE gives phases 0 for DEAD_CYC cycles then (1,1,1); brakei=0 gives phases 0 then the held step codes.
